mic_delay_buf: RTL and testbench
================================

# mic_delay_buf

Parametrised multi-channel circular sample buffer for the delay-and-sum beamformer: stores the last DEPTH frames of CH microphone channels in one inferred simple-dual-port RAM and returns any channel's sample at a requested frame delay. It generalises the fixed 512x16 single-channel SDP RAM to configurable width, depth and channel count. It adds write-pointer management, fill tracking with zero-fill of unwritten history, and a pipelined read port. It sits between the PDM/CIC decimation front end and the beam-sum accumulator.

## Interface
- DATA_W, 16, sample width (two's complement, stored verbatim)
- DEPTH, 512, frames of history per channel; power of two, ≥4
- CH, 8, channel count; power of two, ≥1
- AW = log2(DEPTH), CW = max(1, log2(CH)), derived, not overridable
- clk  in  1  sole clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state below
- clr  in  1  synchronous clear of wptr, fill and err_ch; RAM untouched
- in_valid  in  1  write strobe
- in_ch  in  CW+1  channel index of in_data
- in_data  in  DATA_W  sample
- rd_req  in  1  read request; one accepted per cycle, no backpressure
- rd_ch  in  CW  channel to read
- rd_delay  in  AW  frames back; 0 = most recent complete frame
- rd_valid  out  1  read data valid
- rd_data  out  DATA_W  read sample
- fill  out  AW+1  complete frames stored, saturating at DEPTH
- err_ch  out  1  sticky: in_valid seen with in_ch ≥ CH

## Operation
- RAM: CH*DEPTH words, address {ch, frame_ptr}; read-first on same-address collision.
- Write: in_valid with in_ch < CH writes in_data to {in_ch, wptr}. A write with in_ch == CH-1 closes the frame: wptr <= wptr+1 (mod DEPTH), fill <= min(fill+1, DEPTH).
- Channels are expected in order 0..CH-1. Out-of-order writes are stored as addressed and are not flagged. Only in_ch == CH-1 advances wptr.
- in_valid with in_ch ≥ CH: no write, no pointer change, err_ch <= 1 until reset/clr.
- Read: address = {rd_ch, (wptr − 1 − rd_delay) mod DEPTH}, using wptr as registered in the request cycle.
- rd_delay ≥ fill (sampled at request): rd_valid still asserted, rd_data = 0.
- Frame closed in the same cycle as a request: not visible to that request; visible from the next cycle.
- Collision case (rd_delay = DEPTH−1, fill = DEPTH, write to the current frame of rd_ch): read-first returns the oldest stored sample.
- clr and in_valid in the same cycle: clr wins; the write still lands in RAM at the pre-clear wptr, but fill = 0 afterwards.
- Reset values: rd_valid=0, rd_data=0, fill=0, err_ch=0, wptr=0. The read pipeline is flushed on reset; no rd_valid is produced for requests in flight.

## Timing
- Read latency 2: request at cycle n, RAM read at n+1, output register at n+2 with rd_valid=1 for exactly one cycle per request.
- Full throughput: back-to-back rd_req yields back-to-back rd_valid.
- Zero-gate flag is pipelined alongside the address; rd_data is 0 when rd_valid=0.
- Write visibility: a sample written at cycle n is readable by a request issued at cycle n+1 or later, once its frame is closed.
- fill and wptr update the cycle after the closing write.

## Structure
- Package mic_buf_pkg: default DATA_W/DEPTH/CH constants and a clog2-based width helper.
- One sub-module, sdp_ram: generic inferred simple-dual-port RAM with registered read and read-first semantics, no reset on the array, parameters WIDTH and DEPTH_W. It maps onto the vendor SDPB primitive.
- Top-level: pointer/fill counters, error flag, read-address arithmetic, 2-stage valid/zero-gate pipeline.

## Test plan
- Reset then rd_req ch0 delay 0 → rd_valid at +2, rd_data=0, fill=0.
- Defaults: write 3 frames, sample = {frame,ch} (frame 0 ch 5 = 0x0005, frame 2 ch 3 = 0x0203) → fill=3; read ch3 delay 0 → 0x0203, ch5 delay 2 → 0x0005, ch5 delay 3 → 0.
- Write 600 frames (DEPTH=512) → fill=512, wptr=88; read ch0 delay 511 → frame 88 data; back-to-back reads of delays 0..7 give eight consecutive rd_valid cycles.
- Frame-closing write (ch7) and rd_req delay 0 in the same cycle → returns the previous frame; the same request one cycle later → returns the new frame.
- in_valid with in_ch=8 → err_ch=1, fill unchanged, no RAM change; clr → err_ch=0, fill=0.
- Assert reset with two reads in flight → no rd_valid afterwards, all outputs 0.

Source files
------------

// File: rtl/mic_buf_pkg.sv
// Shared defaults and width helper for the microphone delay buffer.
package mic_buf_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH  = 512;
  localparam int DEF_CH     = 8;

  // Index width for n items; a single item still needs one address bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mic_delay_buf_sdp_ram.sv
// Generic simple-dual-port RAM: one write port, one registered read port,
// read-first on same-address collision, no reset on the storage array.
module sdp_ram #(
  parameter int WIDTH   = 16,
  parameter int DEPTH_W = 9
) (
  input  logic               clk,
  input  logic               we,
  input  logic [DEPTH_W-1:0] waddr,
  input  logic [WIDTH-1:0]   wdata,
  input  logic               re,
  input  logic [DEPTH_W-1:0] raddr,
  output logic [WIDTH-1:0]   rdata
);

  logic [WIDTH-1:0] mem [2**DEPTH_W];

  // Both ports in one process with non-blocking writes gives read-first.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/mic_delay_buf.sv
// Multi-channel circular sample buffer: stores the last DEPTH frames of CH
// channels and returns a channel's sample at a requested frame delay.
module mic_delay_buf
  import mic_buf_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,
  parameter  int CH     = DEF_CH,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = idx_width(CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [CW:0]       in_ch,
  input  logic [DATA_W-1:0] in_data,
  input  logic              rd_req,
  input  logic [CW-1:0]     rd_ch,
  input  logic [AW-1:0]     rd_delay,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [AW:0]       fill,
  output logic              err_ch
);

  logic [AW-1:0]     wptr_reg;
  logic [AW:0]       fill_reg;
  logic              err_ch_reg;
  logic              ch_ok;
  logic              wr_en;
  logic              close_frame;
  logic [AW-1:0]     rd_frame;
  logic              rd_zero;
  logic [DATA_W-1:0] ram_q;
  logic              v1_reg;
  logic              zero1_reg;
  logic              rd_valid_reg;
  logic [DATA_W-1:0] rd_data_reg;

  assign ch_ok       = in_ch < (CW + 1)'(CH);
  assign wr_en       = in_valid && ch_ok;
  assign close_frame = wr_en && (in_ch == (CW + 1)'(CH - 1));

  // clr wins over a closing write; the sample itself still reaches the RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_reg   <= '0;
      fill_reg   <= '0;
      err_ch_reg <= 1'b0;
    end else if (clr) begin
      wptr_reg   <= '0;
      fill_reg   <= '0;
      err_ch_reg <= 1'b0;
    end else begin
      if (close_frame) begin
        wptr_reg <= wptr_reg + 1'b1;
        if (fill_reg != (AW + 1)'(DEPTH)) begin
          fill_reg <= fill_reg + 1'b1;
        end
      end
      if (in_valid && !ch_ok) begin
        err_ch_reg <= 1'b1;
      end
    end
  end

  // Most recent complete frame sits one slot behind the write pointer.
  assign rd_frame = wptr_reg - AW'(1) - rd_delay;
  assign rd_zero  = {1'b0, rd_delay} >= fill_reg;

  sdp_ram #(
    .WIDTH   (DATA_W),
    .DEPTH_W (CW + AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr ({in_ch[CW-1:0], wptr_reg}),
    .wdata (in_data),
    .re    (rd_req),
    .raddr ({rd_ch, rd_frame}),
    .rdata (ram_q)
  );

  // Valid and zero-gate travel alongside the RAM read; reset flushes both.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_reg       <= 1'b0;
      zero1_reg    <= 1'b0;
      rd_valid_reg <= 1'b0;
      rd_data_reg  <= '0;
    end else begin
      v1_reg       <= rd_req;
      zero1_reg    <= rd_zero;
      rd_valid_reg <= v1_reg;
      rd_data_reg  <= (v1_reg && !zero1_reg) ? ram_q : '0;
    end
  end

  assign rd_valid = rd_valid_reg;
  assign rd_data  = rd_data_reg;
  assign fill     = fill_reg;
  assign err_ch   = err_ch_reg;

endmodule

// File: tb/tb_mic_delay_buf.sv
// Directed self-checking bench for mic_delay_buf at default parameters.
module tb_mic_delay_buf;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_ch = '0;
  logic [15:0] in_data = '0;
  logic        rd_req = 1'b0;
  logic [2:0]  rd_ch = '0;
  logic [8:0]  rd_delay = '0;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic [9:0]  fill;
  logic        err_ch;

  int tests_run = 0;
  int tests_failed = 0;
  int valid_cnt;

  mic_delay_buf dut (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ch    (in_ch),
    .in_data  (in_data),
    .rd_req   (rd_req),
    .rd_ch    (rd_ch),
    .rd_delay (rd_delay),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .fill     (fill),
    .err_ch   (err_ch)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Frame number in the top byte plus bits 9:8, channel in the low nibble.
  function automatic logic [15:0] sample(input int frame, input int ch);
    return {frame[7:0], 2'b00, frame[9:8], ch[3:0]};
  endfunction

  task automatic write_frame(input int frame);
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1;
      in_ch    = 4'(c);
      in_data  = sample(frame, c);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic read_check(input string tag, input int ch, input int delay, input logic [15:0] exp);
    rd_req   = 1'b1;
    rd_ch    = 3'(ch);
    rd_delay = 9'(delay);
    step();
    rd_req = 1'b0;
    check_val({tag, "_lat1"}, 32'(rd_valid), 32'd0);
    step();
    check_val({tag, "_valid"}, 32'(rd_valid), 32'd1);
    check_val({tag, "_data"}, 32'(rd_data), 32'(exp));
    $display("[TB] read ch%0d delay %0d -> 0x%04h (want 0x%04h)", ch, delay, rd_data, exp);
    step();
    check_val({tag, "_once"}, 32'(rd_valid), 32'd0);
    check_val({tag, "_gate"}, 32'(rd_data), 32'd0);
  endtask

  initial begin
    repeat (3) step();
    reset = 1'b0;
    step();
    check_val("rst_valid", 32'(rd_valid), 32'd0);
    check_val("rst_data", 32'(rd_data), 32'd0);
    check_val("rst_fill", 32'(fill), 32'd0);
    check_val("rst_err", 32'(err_ch), 32'd0);
    read_check("empty_rd", 0, 0, 16'h0000);

    for (int f = 0; f < 3; f++) write_frame(f);
    check_val("fill3", 32'(fill), 32'd3);
    read_check("f3_ch3_d0", 3, 0, 16'h0203);
    read_check("f3_ch5_d2", 5, 2, 16'h0005);
    read_check("f3_ch5_d3", 5, 3, 16'h0000);

    for (int f = 3; f < 600; f++) write_frame(f);
    $display("[TB] wrote 600 frames, fill=%0d", fill);
    check_val("fill_sat", 32'(fill), 32'd512);
    read_check("oldest", 0, 511, sample(88, 0));
    read_check("newest", 0, 0, sample(599, 0));

    // Back-to-back reads of delays 0..7 on ch2.
    valid_cnt = 0;
    for (int t = 0; t < 10; t++) begin
      rd_req   = (t < 8);
      rd_ch    = 3'd2;
      rd_delay = 9'(t);
      step();
      if (rd_valid) valid_cnt++;
      if (t >= 1 && t <= 8) begin
        check_val($sformatf("burst%0d_valid", t - 1), 32'(rd_valid), 32'd1);
        check_val($sformatf("burst%0d_data", t - 1), 32'(rd_data), 32'(sample(600 - t, 2)));
        $display("[TB] burst read delay %0d -> 0x%04h", t - 1, rd_data);
      end
    end
    rd_req = 1'b0;
    check_val("burst_count", 32'(valid_cnt), 32'd8);

    // Closing write and request in the same cycle, then one cycle later.
    for (int c = 0; c < 7; c++) begin
      in_valid = 1'b1;
      in_ch    = 4'(c);
      in_data  = sample(600, c);
      step();
    end
    in_ch    = 4'd7;
    in_data  = sample(600, 7);
    rd_req   = 1'b1;
    rd_ch    = 3'd7;
    rd_delay = 9'd0;
    step();
    in_valid = 1'b0;
    step();
    rd_req = 1'b0;
    check_val("close_same_valid", 32'(rd_valid), 32'd1);
    check_val("close_same_data", 32'(rd_data), 32'(sample(599, 7)));
    $display("[TB] same-cycle close read -> 0x%04h", rd_data);
    step();
    check_val("close_next_valid", 32'(rd_valid), 32'd1);
    check_val("close_next_data", 32'(rd_data), 32'(sample(600, 7)));
    $display("[TB] next-cycle read -> 0x%04h", rd_data);
    step();

    // Write to the oldest slot while reading it: old contents come back.
    in_valid = 1'b1;
    in_ch    = 4'd0;
    in_data  = sample(601, 0);
    rd_req   = 1'b1;
    rd_ch    = 3'd0;
    rd_delay = 9'd511;
    step();
    in_valid = 1'b0;
    rd_req   = 1'b0;
    step();
    check_val("rf_valid", 32'(rd_valid), 32'd1);
    check_val("rf_data", 32'(rd_data), 32'(sample(89, 0)));
    $display("[TB] read-first collision -> 0x%04h", rd_data);
    step();

    // Out-of-range channel indices.
    in_valid = 1'b1;
    in_ch    = 4'd8;
    in_data  = 16'hDEAD;
    step();
    in_ch    = 4'd15;
    in_data  = 16'hBEEF;
    step();
    in_valid = 1'b0;
    $display("[TB] bad channel writes, err_ch=%0d fill=%0d", err_ch, fill);
    check_val("err_set", 32'(err_ch), 32'd1);
    check_val("err_fill", 32'(fill), 32'd512);
    read_check("err_noram", 0, 511, sample(601, 0));
    read_check("err_noadv", 7, 0, sample(600, 7));

    clr = 1'b1;
    step();
    clr = 1'b0;
    $display("[TB] clr, err_ch=%0d fill=%0d", err_ch, fill);
    check_val("clr_err", 32'(err_ch), 32'd0);
    check_val("clr_fill", 32'(fill), 32'd0);
    read_check("clr_rd", 7, 0, 16'h0000);

    // Reset with reads in flight.
    write_frame(700);
    check_val("pre_rst_fill", 32'(fill), 32'd1);
    rd_req   = 1'b1;
    rd_ch    = 3'd1;
    rd_delay = 9'd0;
    step();
    #2;
    reset  = 1'b1;
    rd_req = 1'b0;
    #1;
    check_val("inrst_valid", 32'(rd_valid), 32'd0);
    check_val("inrst_fill", 32'(fill), 32'd0);
    step();
    reset = 1'b0;
    valid_cnt = 0;
    for (int t = 0; t < 3; t++) begin
      step();
      if (rd_valid) valid_cnt++;
      check_val($sformatf("postrst_data%0d", t), 32'(rd_data), 32'd0);
    end
    $display("[TB] reset with reads in flight, valids seen=%0d", valid_cnt);
    check_val("postrst_valid", 32'(valid_cnt), 32'd0);
    check_val("postrst_err", 32'(err_ch), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
